// File: rtl/flopr_skid.sv
// Two-entry registered skid buffer: valid/ready on both sides, all outputs from flops.
// state | meaning
// EMPTY | no word held, out_valid low
// BUSY  | one word in main (head)
// FULL  | main is head, skid holds the next word, in_ready low
module flopr_skid #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A flush drops whatever would have been captured; stored words keep their old contents.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = state_q;

endmodule

// File: tb/tb_flopr_skid.sv
// Directed bench for flopr_skid: vector table for steady-state behaviour,
// hand-written sequences for reset and asynchronous reset while FULL.
module tb_flopr_skid;

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [1:0]  exp_count;
    logic [63:0] exp_out_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  flopr_skid #(.N(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ir, input logic ov,
                         input logic [1:0] cnt, input logic [63:0] od);
    chk({tag, " in_ready"},  {63'd0, in_ready},  {63'd0, ir});
    chk({tag, " out_valid"}, {63'd0, out_valid}, {63'd0, ov});
    chk({tag, " count"},     {62'd0, count},     {62'd0, cnt});
    chk({tag, " out_data"},  out_data,           od);
  endtask

  function automatic void add(input logic fl, input logic iv, input logic [63:0] id,
                              input logic ordy, input logic ir, input logic ov,
                              input logic [1:0] cnt, input logic [63:0] od);
    vec_t v;
    v.flush = fl; v.in_valid = iv; v.in_data = id; v.out_ready = ordy;
    v.exp_in_ready = ir; v.exp_out_valid = ov; v.exp_count = cnt; v.exp_out_data = od;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic fl, input logic iv, input logic [63:0] id, input logic ordy);
    flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] w;

    // Reset held for three edges with in_valid asserted.
    reset = 1'b0;
    drive(1'b0, 1'b1, 64'h99, 1'b1);
    #1;
    chk_all("reset t0", 1'b0, 1'b0, 2'd0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_all($sformatf("reset cyc%0d", i), 1'b0, 1'b0, 2'd0, 64'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_all("first edge", 1'b1, 1'b0, 2'd0, 64'h0);

    // Streaming at one word per cycle.
    w = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      add(1'b0, 1'b1, w, 1'b1, 1'b1, 1'b1, 2'd1, w);
      w = w - 64'd1;
    end
    add(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFF6);

    // Backpressure: third word waits upstream, then drains in order.
    add(1'b0, 1'b1, 64'h1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h1);
    add(1'b0, 1'b1, 64'h2, 1'b0, 1'b0, 1'b1, 2'd2, 64'h1);
    add(1'b0, 1'b1, 64'h3, 1'b0, 1'b0, 1'b1, 2'd2, 64'h1);
    add(1'b0, 1'b1, 64'h3, 1'b0, 1'b0, 1'b1, 2'd2, 64'h1);
    add(1'b0, 1'b1, 64'h3, 1'b1, 1'b1, 1'b1, 2'd1, 64'h2);
    add(1'b0, 1'b1, 64'h3, 1'b1, 1'b1, 1'b1, 2'd1, 64'h3);
    add(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 2'd0, 64'h3);

    // Simultaneous accept and deliver in BUSY.
    add(1'b0, 1'b1, 64'hA, 1'b0, 1'b1, 1'b1, 2'd1, 64'hA);
    add(1'b0, 1'b1, 64'hB, 1'b1, 1'b1, 1'b1, 2'd1, 64'hB);
    add(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 2'd0, 64'hB);

    // Flush from FULL with out_ready high; 6 must never surface.
    add(1'b0, 1'b1, 64'h5, 1'b0, 1'b1, 1'b1, 2'd1, 64'h5);
    add(1'b0, 1'b1, 64'h6, 1'b0, 1'b0, 1'b1, 2'd2, 64'h5);
    add(1'b1, 1'b1, 64'h9, 1'b1, 1'b1, 1'b0, 2'd0, 64'h5);
    add(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 2'd0, 64'h5);
    add(1'b0, 1'b1, 64'h8, 1'b0, 1'b1, 1'b1, 2'd1, 64'h8);
    // Flush in BUSY drops a concurrent accept.
    add(1'b1, 1'b1, 64'h9, 1'b0, 1'b1, 1'b0, 2'd0, 64'h8);
    add(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 2'd0, 64'h8);

    foreach (vecs[i]) begin
      drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid,
              vecs[i].exp_count, vecs[i].exp_out_data);
    end

    // Asynchronous reset while FULL.
    drive(1'b0, 1'b1, 64'h10, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 64'h11, 1'b0);
    @(posedge clk); #1;
    chk_all("pre-async full", 1'b0, 1'b1, 2'd2, 64'h10);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async clear", 1'b0, 1'b0, 2'd0, 64'h0);
    drive(1'b0, 1'b1, 64'h7, 1'b1);
    @(posedge clk); #1;
    chk_all("async held", 1'b0, 1'b0, 2'd0, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_all("async first edge", 1'b1, 1'b0, 2'd0, 64'h0);
    @(posedge clk); #1;
    chk_all("async push 7", 1'b1, 1'b1, 2'd1, 64'h7);
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    @(posedge clk); #1;
    chk_all("async drain", 1'b1, 1'b0, 2'd0, 64'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
